// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button inputs and counter/display control outputs of the stopwatch sequencer
interface stopwatch_ctrl_if;
  logic       btn_ss;
  logic       btn_lr;
  logic       sec_tick;
  logic       count_clr;
  logic       lap_hold;
  logic [1:0] state_out;
  modport master (output btn_ss, btn_lr, input sec_tick, count_clr, lap_hold, state_out);
  modport slave  (input btn_ss, btn_lr, output sec_tick, count_clr, lap_hold, state_out);
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, run/pause/lap/reset FSM and one-second prescaler
// STOPWATCH_LAP_TIMEOUT_EN adds automatic lap release after LAP_HOLD_SECS seconds
module stopwatch_ctrl #(
  parameter int TICK_CYCLES     = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LAP_HOLD_SECS   = 5
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave sw
);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, LAP = 2'b10, PAUSE = 2'b11} state_t;
  state_t        state_q, state_d;
  logic [1:0]    raw, press;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, clr_q, clr_d, hold_q, counting, timeout, ss, lr;
  assign raw = {sw.btn_lr, sw.btn_ss};
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic          sync1_q, sync2_q, deb_q, prev_q;
    logic [DW-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        prev_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw[b];
        sync2_q <= sync1_q;
        prev_q  <= deb_q;
        if (sync2_q == deb_q) cnt_q <= '0;
        else if (cnt_q == DB_LAST) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else cnt_q <= cnt_q + 1'b1;
      end
    end
    assign press[b] = deb_q & ~prev_q;
  end
  assign ss = press[0];
  assign lr = press[1];
  // start/stop outranks lap/reset when both arrive together
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      IDLE:    begin
        state_d = ss ? RUN : IDLE;
        clr_d   = !ss && lr;
      end
      RUN:     state_d = ss ? PAUSE : lr ? LAP : RUN;
      LAP:     state_d = ss ? PAUSE : (lr || timeout) ? RUN : LAP;
      PAUSE:   begin
        state_d = ss ? RUN : lr ? IDLE : PAUSE;
        clr_d   = !ss && lr;
      end
      default: state_d = IDLE;
    endcase
  end
  assign counting = state_q == RUN || state_q == LAP;
  assign pre_d = counting ? (pre_q == PRE_LAST ? '0 : pre_q + 1'b1) : (state_d == IDLE ? '0 : pre_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= counting && pre_q == PRE_LAST;
      clr_q   <= clr_d;
      hold_q  <= state_d == LAP;
    end
  end
`ifdef STOPWATCH_LAP_TIMEOUT_EN
  localparam int LW = $clog2(LAP_HOLD_SECS + 1);
  localparam logic [LW-1:0] LAP_LAST = LW'(LAP_HOLD_SECS - 1);
  logic [LW-1:0] lap_q;
  // fires on the final tick so RUN is entered the cycle after it
  assign timeout = state_q == LAP && tick_q && lap_q == LAP_LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lap_q <= '0;
    else lap_q <= (state_q == LAP && state_d == LAP) ? lap_q + LW'(tick_q) : '0;
  end
`else
  assign timeout = 1'b0;
`endif
  assign sw.sec_tick  = tick_q;
  assign sw.count_clr = clr_q;
  assign sw.lap_hold  = hold_q;
  assign sw.state_out = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed table and sequence checks of stopwatch_ctrl with TICK_CYCLES=10, DEBOUNCE_CYCLES=4
module tb_stopwatch_ctrl;
  typedef struct {
    logic       ss;
    logic       lr;
    logic [1:0] st;
    logic       lap;
    logic       clr;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t tbl[14];
  stopwatch_ctrl_if sw();
  stopwatch_ctrl #(.TICK_CYCLES(10), .DEBOUNCE_CYCLES(4), .LAP_HOLD_SECS(3)) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // button reaches the FSM 7 edges after rising: 2 sync + 4 debounce + 1 state register
  task automatic press(input logic ss, input logic lr, input logic [1:0] prev,
                       input logic [1:0] st, input logic lap, input logic clr);
    sw.btn_ss = ss;
    sw.btn_lr = lr;
    step(6);
    chk("press_latency", sw.state_out, prev);
    step(1);
    chk("press_state", sw.state_out, st);
    chk("press_lap_hold", sw.lap_hold, lap);
    chk("press_count_clr", sw.count_clr, clr);
  endtask
  task automatic release_btns();
    sw.btn_ss = 1'b0;
    sw.btn_lr = 1'b0;
    step(1);
    chk("count_clr_width", sw.count_clr, 0);
    step(7);
  endtask
  initial begin
    int nt, t3, tx, bad;
    logic [1:0] prev;
    tbl[0]  = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
    sw.btn_ss = 1'b0;
    sw.btn_lr = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("reset_state", sw.state_out, 0);
    chk("reset_sec_tick", sw.sec_tick, 0);
    chk("reset_count_clr", sw.count_clr, 0);
    chk("reset_lap_hold", sw.lap_hold, 0);
    // glitchy button never stays stable for 4 synced cycles
    for (int i = 1; i <= 27; i++) begin
      sw.btn_ss = (i <= 3) || (i >= 5 && i <= 7);
      step(1);
      chk("glitch_state", sw.state_out, 0);
      chk("glitch_sec_tick", sw.sec_tick, 0);
    end
    press(1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
    // t counts edges after RUN entry; button held 20 cycles, re-pressed so PAUSE lands at prescaler 6
    for (int t = 1; t <= 36; t++) begin
      sw.btn_ss = (t < 14) || (t >= 30);
      step(1);
      chk("run_sec_tick", sw.sec_tick, (t % 10 == 0) ? 1 : 0);
      chk("run_state", sw.state_out, (t == 36) ? 3 : 1);
    end
    for (int u = 1; u <= 56; u++) begin
      sw.btn_ss = (u >= 50);
      step(1);
      chk("pause_sec_tick", sw.sec_tick, 0);
      chk("pause_state", sw.state_out, (u == 56) ? 1 : 3);
    end
    for (int v = 1; v <= 10; v++) begin
      sw.btn_ss = 1'b0;
      step(1);
      chk("resume_sec_tick", sw.sec_tick, (v == 4) ? 1 : 0);
    end
    step(2);
    prev = 2'b01;
    for (int i = 0; i < 14; i++) begin
      press(tbl[i].ss, tbl[i].lr, prev, tbl[i].st, tbl[i].lap, tbl[i].clr);
      release_btns();
      prev = tbl[i].st;
    end
    press(1'b1, 1'b0, 2'b01, 2'b11, 1'b0, 1'b0);
    release_btns();
    press(1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1);
    release_btns();
    press(1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
    for (int t = 1; t <= 10; t++) begin
      sw.btn_ss = 1'b0;
      step(1);
      chk("clear_restart_tick", sw.sec_tick, (t == 10) ? 1 : 0);
    end
    press(1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0);
    sw.btn_lr = 1'b0;
    nt = 0;
`ifdef STOPWATCH_LAP_TIMEOUT_EN
    t3 = -1;
    tx = -1;
    for (int t = 1; t <= 40 && tx < 0; t++) begin
      step(1);
      if (sw.state_out != 2'b10) tx = t;
      else if (sw.sec_tick) begin
        nt++;
        if (nt == 3) t3 = t;
      end
    end
    chk("lap_timeout_ticks", nt, 3);
    chk("lap_timeout_cycle", tx, t3 + 1);
    chk("lap_timeout_state", sw.state_out, 1);
    chk("lap_timeout_hold", sw.lap_hold, 0);
    step(8);
    press(1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0);
`else
    bad = 0;
    for (int t = 1; t <= 1000; t++) begin
      step(1);
      nt += int'(sw.sec_tick);
      if (sw.state_out != 2'b10 || !sw.lap_hold) bad++;
    end
    chk("lap_persist_ticks", nt, 100);
    chk("lap_persist_bad_cycles", bad, 0);
`endif
    #3 rst = 1'b1;
    #1;
    chk("async_rst_state", sw.state_out, 0);
    chk("async_rst_lap_hold", sw.lap_hold, 0);
    chk("async_rst_sec_tick", sw.sec_tick, 0);
    chk("async_rst_count_clr", sw.count_clr, 0);
    step(1);
    chk("rst_held_state", sw.state_out, 0);
    rst = 1'b0;
    sw.btn_lr = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
